// File: rtl/biquad8_power_trigger_if.sv
// Sample/trigger bus between the biquad cascade, the power trigger and its consumer.
interface biquad8_power_trigger_if #(
    parameter int NBITS = 12,
    parameter int NSAMP = 8
);
    logic [NBITS*NSAMP-1:0] dat_i;
    logic                   enable_i;
    logic [31:0]            thresh_i;
    logic [NBITS*NSAMP-1:0] dat_o;
    logic [31:0]            power_o;
    logic                   trig_o;
    logic [15:0]            trig_count_o;

    modport master (
        output dat_i, enable_i, thresh_i,
        input  dat_o, power_o, trig_o, trig_count_o
    );

    modport slave (
        input  dat_i, enable_i, thresh_i,
        output dat_o, power_o, trig_o, trig_count_o
    );
endinterface

// File: rtl/biquad8_power_trigger.sv
// Windowed-power trigger on a multi-sample-per-clock biquad output.
//   state     | meaning
//   IDLE      | disarmed, waiting for enable_i
//   ARMED     | comparing power_o against thresh_i every clock
//   FIRE      | one-clock trigger, trig_o high
//   HOLDOFF   | dead time, down-counter runs to 0 regardless of enable_i
module biquad8_power_trigger #(
    parameter int NBITS   = 12,
    parameter int NSAMP   = 8,
    parameter int NWIN    = 4,
    parameter int HOLDOFF = 16
) (
    input logic aclk,
    input logic aresetn,
    biquad8_power_trigger_if.slave bus
);
    localparam int SQW  = 2*NBITS - 1;
    localparam int SUMW = SQW + $clog2(NSAMP);
    localparam int PWRW = SUMW + $clog2(NWIN);
    localparam int DW   = NBITS*NSAMP;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FIRE, S_HOLDOFF} state_t;

    logic [1:0]       sync_q;
    logic             rst_sync_n;
    logic [NBITS-1:0] lane  [NSAMP];
    logic [NBITS-1:0] mag   [NSAMP];
    logic [SQW-1:0]   sq_d  [NSAMP];
    logic [SQW-1:0]   sq_q  [NSAMP];
    logic [SUMW-1:0]  sum_d;
    logic [SUMW-1:0]  sum_q;
    logic [SUMW-1:0]  hist  [NWIN];
    logic [PWRW-1:0]  pwr_d;
    logic [PWRW-1:0]  pwr_q;
    logic [DW-1:0]    dly   [4];
    state_t           state;
    logic [15:0]      hold_cnt;
    logic             trig_q;
    logic [15:0]      count_q;

    // Assert immediately, release two clocks later so every flop leaves reset together.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], 1'b1};
    end
    assign rst_sync_n = sync_q[1];

    // Square via magnitude: |-2^(NBITS-1)| still fits NBITS unsigned bits.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NSAMP; k++) begin
            lane[k] = bus.dat_i[k*NBITS +: NBITS];
            mag[k]  = lane[k][NBITS-1] ? (~lane[k] + NBITS'(1)) : lane[k];
            sq_d[k] = SQW'(mag[k]) * SQW'(mag[k]);
            sum_d   = sum_d + SUMW'(sq_q[k]);
        end
    end

    // Modular arithmetic is exact because the true window sum always fits PWRW bits.
    assign pwr_d = pwr_q + PWRW'(sum_q) - PWRW'(hist[NWIN-1]);

    always_ff @(posedge aclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            for (int k = 0; k < NSAMP; k++) sq_q[k] <= '0;
            for (int w = 0; w < NWIN; w++)  hist[w] <= '0;
            for (int d = 0; d < 4; d++)     dly[d]  <= '0;
            sum_q <= '0;
            pwr_q <= '0;
        end else begin
            for (int k = 0; k < NSAMP; k++) sq_q[k] <= sq_d[k];
            hist[0] <= sum_q;
            for (int w = 1; w < NWIN; w++)  hist[w] <= hist[w-1];
            dly[0] <= bus.dat_i;
            for (int d = 1; d < 4; d++)     dly[d]  <= dly[d-1];
            sum_q <= sum_d;
            pwr_q <= pwr_d;
        end
    end

    always_ff @(posedge aclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            trig_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            trig_q <= 1'b0;
            case (state)
                S_IDLE: if (bus.enable_i) state <= S_ARMED;
                S_ARMED: begin
                    if (!bus.enable_i) begin
                        state <= S_IDLE;
                    end else if (bus.power_o > bus.thresh_i) begin
                        state  <= S_FIRE;
                        trig_q <= 1'b1;
                        if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
                    end
                end
                S_FIRE: begin
                    state    <= S_HOLDOFF;
                    hold_cnt <= 16'(HOLDOFF - 1);
                end
                S_HOLDOFF: begin
                    if (hold_cnt == 16'd0) state <= bus.enable_i ? S_ARMED : S_IDLE;
                    else                   hold_cnt <= hold_cnt - 16'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.dat_o        = dly[3];
    assign bus.power_o      = {{(32-PWRW){1'b0}}, pwr_q};
    assign bus.trig_o       = trig_q;
    assign bus.trig_count_o = count_q;
endmodule

// File: doc/biquad8_power_trigger.md
BIQUAD8_POWER_TRIGGER -- requirements
Module: biquad8_power_trigger

Interface
REQ-001 Parameter NBITS, default 12, SHALL set the signed sample width per lane.
REQ-002 Parameter NSAMP, default 8, SHALL set the number of samples per clock.
REQ-003 Parameter NWIN, default 4, SHALL set the window length in clocks; legal values are powers of two from 2 to 16.
REQ-004 Parameter HOLDOFF, default 16, SHALL set the post-trigger dead time in clocks; legal range is 1 to 65535.
REQ-005 aclk  input  1  SHALL be the sole clock; all logic is rising-edge.
REQ-006 aresetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 dat_i  input  96  SHALL carry 8 signed 12-bit samples, lane k at [12k+:12], valid every clock, from the biquad cascade output.
REQ-008 enable_i  input  1  SHALL arm the trigger when high.
REQ-009 thresh_i  input  32  SHALL be the unsigned power threshold.
REQ-010 dat_o  output  96  SHALL be dat_i delayed, aligned to trig_o.
REQ-011 power_o  output  32  SHALL be the unsigned windowed power, zero-extended.
REQ-012 trig_o  output  1  SHALL be a single-cycle trigger pulse.
REQ-013 trig_count_o  output  16  SHALL be the count of triggers fired.

Function
REQ-014 Stage 1 (edge 1 after dat_i) SHALL register the 8 lane squares, each unsigned 23 bits; (-2048)^2 = 4194304 SHALL be exact.
REQ-015 Stage 2 (edge 2) SHALL register the per-clock sum of 8 squares, unsigned 26 bits, without truncation.
REQ-016 Stage 3 (edge 3) SHALL update power_o to the sum of the last NWIN per-clock sums: add newest, subtract the one leaving the window.
REQ-017 power_o width before extension SHALL be 26+log2(NWIN) bits, and SHALL never overflow or wrap.
REQ-018 Window history SHALL be zero after reset, so power_o ramps over NWIN clocks.
REQ-019 dat_o SHALL be dat_i delayed by exactly 4 clocks.
REQ-020 The FSM SHALL have states IDLE, ARMED, FIRE, and HOLDOFF.
REQ-021 IDLE SHALL go to ARMED when enable_i=1.
REQ-022 ARMED SHALL go to IDLE when enable_i=0.
REQ-023 ARMED SHALL go to FIRE when enable_i=1 and power_o > thresh_i, strictly greater.
REQ-024 When power_o equals thresh_i, ARMED SHALL NOT fire.
REQ-025 FIRE SHALL last exactly one clock, then enter HOLDOFF with the counter loaded to HOLDOFF-1.
REQ-026 HOLDOFF SHALL decrement each clock.
REQ-027 When the HOLDOFF counter is 0, the FSM SHALL go to ARMED if enable_i=1, else to IDLE.
REQ-028 A drop of enable_i during HOLDOFF SHALL NOT shorten HOLDOFF.
REQ-029 trig_o SHALL equal (state==FIRE) as a registered signal, i.e. 4 clocks after the dat_i word that caused it.
REQ-030 Minimum spacing between trig_o pulses SHALL be HOLDOFF+2 clocks.
REQ-031 trig_count_o SHALL increment on entry to FIRE and saturate at 0xFFFF.
REQ-032 thresh_i SHALL be used combinationally each ARMED cycle and SHALL NOT be latched.

Reset
REQ-033 aresetn low SHALL immediately clear the pipeline, window history, HOLDOFF counter, dat_o, power_o, trig_o and trig_count_o to 0, and force the state to IDLE.
REQ-034 Release of aresetn SHALL be synchronized internally (2-flop), and operation SHALL resume on the first clock after the synchronized deassert.
REQ-035 Reset asserted mid-HOLDOFF or mid-FIRE SHALL abort the sequence with no further trig_o.

Verification
REQ-036 All lanes=100, NWIN=4, thresh=0xFFFFFFFF: power_o SHALL read 80000, 160000, 240000, 320000 on edges 3..6, then hold 320000; trig_o SHALL stay 0.
REQ-037 All lanes=-2048, NWIN=16: per-clock sum SHALL be 33554432 and power_o SHALL settle at 536870912 with no wrap.
REQ-038 Steady power_o=320000 with thresh=320000: there SHALL be no trigger; with thresh=319999, trig_o SHALL pulse 4 clocks after the first qualifying word, with dat_o matching that word.
REQ-039 Continuous above-threshold input, HOLDOFF=16, enable_i=1: trig_o SHALL pulse every 18 clocks, and trig_count_o SHALL step 1, 2, 3, ...
REQ-040 enable_i dropped 3 clocks into HOLDOFF: HOLDOFF SHALL complete, then IDLE; there SHALL be no further pulses, and trig_count_o SHALL be frozen.
REQ-041 aresetn pulsed low during HOLDOFF with trig_count_o=5: all outputs SHALL be 0 at once and the state IDLE; after release with enable_i=1, the first trigger SHALL set trig_count_o=1.
